feistel_function: RTL and testbench
===================================

Name: feistel_function

Overview:
- Implements the DES round function f(R, K): E-expansion, XOR with the 48-bit round subkey, eight S-box substitutions, then the P permutation.
- Sits inside the DES round datapath, between the key schedule (which supplies the subkey) and the L/R swap-XOR stage.
- The output is registered, giving one clock of latency.

Parameters:
- none. All DES tables are fixed constants from the shared package.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  R_in/subkey are valid this cycle
- R_in  input  32  right half-block; bit 31 = DES bit 1 (MSB-first)
- subkey  input  48  round key; bit 47 = DES bit 1
- out_valid  output  1  f_out holds the result for the inputs of the previous in_valid cycle
- f_out  output  32  f(R_in, subkey); bit 31 = DES bit 1

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0, f_out=32'h0 and out_valid=0, regardless of clock.
- Datapath is purely combinational up to a single output register.
- Combinational steps, all indices in DES 1-based MSB-first numbering:
  - E: 32->48 using the standard FIPS 46-3 E table.
  - X = E(R_in) XOR subkey.
  - Split X into eight 6-bit groups B1..B8, with B1 = X[47:42].
  - Si row = {b1,b6}, column = {b2..b5}. Each Si yields a 4-bit value; S1 lands in the MSBs of the 32-bit word.
  - P: standard FIPS 46-3 32->32 permutation gives the result.
- Timing:
  - Each rising clk with in_valid=1: f_out <= f(R_in, subkey); out_valid <= 1.
  - Each rising clk with in_valid=0: f_out holds its value; out_valid <= 0.
  - Latency is exactly 1 cycle; throughput is one result per cycle. There is no backpressure.
- Inputs may change every cycle; only the values sampled at the clock edge matter.
- No X propagation from unused states. All 2^80 input combinations are legal.
- Reset asserted mid-stream clears f_out and out_valid immediately. The first result after rst_n deasserts comes one cycle after the first sampled in_valid.
- Symmetry property the bench relies on: f(R, K) depends only on E(R)^K. Therefore f(0,0) = f(FFFFFFFF, FFFFFFFFFFFF) = D8D8DBBC.

Decomposition:
- Package des_pkg holds:
  - E table (48 entries)
  - P table (32 entries)
  - S-box contents, S1..S8, 64 x 4-bit each
  - width constants: BLOCK_HALF_W=32, SUBKEY_W=48
  - a helper function applying a permutation table to a vector.
- One sub-module: des_sbox.
  - Ports: sel (3-bit box index, constant at instantiation), in6, out4.
  - Instantiated 8 times with indices 0..7.
- E and P stay as pure wiring in the top module.

Test Plan:
For every case: drive in_valid=1 for one cycle, then check out_valid=1 and f_out on the next cycle.
- Reset: assert rst_n=0 mid-operation -> f_out=00000000 and out_valid=0 immediately, without waiting for a clock edge.
- Zero and all-ones vectors:
  - R=00000000, K=000000000000 -> D8D8DBBC
  - R=FFFFFFFF, K=FFFFFFFFFFFF -> D8D8DBBC
  - R=00010000, K=000000000000 -> D89CDB7C
- DES round vectors, first set:
  - R=80668066, K=38ACEF46564A -> 4B7DD382
  - R=3328ABD7, K=89BED4489D12 -> D3FCA973
- DES round vectors, second set:
  - R=539A2915, K=547EEE4D443C -> 3BB7B4EF
  - R=089F1F38, K=F2F5604958C8 -> C84FFFFC
  - R=5CD39874, K=EABDC2D8CEFB -> 5020E9B2
- Back-to-back streaming: apply the 8 vectors above on consecutive cycles with in_valid held high. Each result must appear exactly one cycle after its input, and out_valid must stay high throughout.
- Hold behaviour: drop in_valid after a vector -> out_valid=0 on the next cycle and f_out unchanged. Also change R_in while in_valid=0 -> f_out unchanged.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES constants: E/P bit-selection tables, S-box contents and the bit-pick helper.
package des_pkg;

  localparam int unsigned BLOCK_HALF_W = 32;
  localparam int unsigned SUBKEY_W     = 48;

  // E expansion: output position i (0 = DES bit 1) takes this DES input bit.
  localparam int unsigned E_TABLE [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
  };

  // P permutation: output position i (0 = DES bit 1) takes this DES input bit.
  localparam int unsigned P_TABLE [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
  };

  // S1..S8, one 256-bit word per box. Entry (row, col) sits at nibble row*16+col,
  // nibble 0 in the MSBs, so each 16-digit group below is one table row.
  localparam logic [255:0] SBOX_TABLE [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Pick DES bit 'pos' (1-based, MSB-first) of a 32-bit word; applying a table
  // bit by bit with this helper yields the permuted vector.
  function automatic logic des_bit(input logic [31:0] vec, input int unsigned pos);
    return vec[5'(32 - pos)];
  endfunction

endpackage

// File: rtl/des_sbox.sv
// One DES S-box lookup; sel picks which of S1..S8 (tied off at instantiation).
module des_sbox
  import des_pkg::*;
(
  input  logic [2:0] sel,
  input  logic [5:0] in6,
  output logic [3:0] out4
);

  logic [255:0] box;
  logic [3:0]   nibbles [64];
  logic [5:0]   entry;

  // Row is {b1,b6}, column is b2..b5, giving entry = row*16 + col.
  assign entry = {in6[5], in6[0], in6[4:1]};
  assign box   = SBOX_TABLE[sel];

  for (genvar k = 0; k < 64; k++) begin : g_nib
    assign nibbles[k] = box[255 - 4*k -: 4];
  end

  assign out4 = nibbles[entry];

endmodule

// File: rtl/feistel_function.sv
// DES round function f(R, K) with a single registered output stage.
module feistel_function
  import des_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [BLOCK_HALF_W-1:0] R_in,
  input  logic [SUBKEY_W-1:0]     subkey,
  output logic                    out_valid,
  output logic [BLOCK_HALF_W-1:0] f_out
);

  logic [SUBKEY_W-1:0]     expanded;
  logic [SUBKEY_W-1:0]     mixed;
  logic [BLOCK_HALF_W-1:0] sbox_out;
  logic [BLOCK_HALF_W-1:0] f_d;
  logic [BLOCK_HALF_W-1:0] f_q;
  logic                    valid_q;

  // E expansion is pure wiring; vector bit 47 is DES bit 1.
  for (genvar i = 0; i < 48; i++) begin : g_e
    assign expanded[47 - i] = des_bit(R_in, E_TABLE[i]);
  end

  assign mixed = expanded ^ subkey;

  // B1 = mixed[47:42] feeds S1, whose result lands in the top nibble.
  for (genvar i = 0; i < 8; i++) begin : g_sbox
    des_sbox u_sbox (
      .sel  (3'(i)),
      .in6  (mixed[47 - 6*i -: 6]),
      .out4 (sbox_out[31 - 4*i -: 4])
    );
  end

  // P permutation is pure wiring.
  for (genvar i = 0; i < 32; i++) begin : g_p
    assign f_d[31 - i] = des_bit(sbox_out, P_TABLE[i]);
  end

  // Output register: capture on in_valid, otherwise hold the result and drop valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        f_q <= f_d;
      end
    end
  end

  assign f_out     = f_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_feistel_function.sv
// Directed bench for feistel_function with a scoreboard of expected round outputs.
module tb_feistel_function;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] R_in;
  logic [47:0] subkey;
  logic        out_valid;
  logic [31:0] f_out;

  feistel_function dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .R_in      (R_in),
    .subkey    (subkey),
    .out_valid (out_valid),
    .f_out     (f_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_q [$];
  string       tag_q [$];
  logic [31:0] held_f;

  logic [31:0] vec_r [8] = '{32'h00000000, 32'hFFFFFFFF, 32'h00010000, 32'h80668066,
                             32'h3328ABD7, 32'h539A2915, 32'h089F1F38, 32'h5CD39874};
  logic [47:0] vec_k [8] = '{48'h000000000000, 48'hFFFFFFFFFFFF, 48'h000000000000,
                             48'h38ACEF46564A, 48'h89BED4489D12, 48'h547EEE4D443C,
                             48'hF2F5604958C8, 48'hEABDC2D8CEFB};
  logic [31:0] vec_f [8] = '{32'hD8D8DBBC, 32'hD8D8DBBC, 32'hD89CDB7C, 32'h4B7DD382,
                             32'hD3FCA973, 32'h3BB7B4EF, 32'hC84FFFFC, 32'h5020E9B2};

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check what the previous edge produced, then drive the next inputs.
  task automatic step(input logic v, input logic [31:0] r, input logic [47:0] k,
                      input logic [31:0] exp, input string tag);
    string t;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      held_f = sb_q.pop_front();
      t      = tag_q.pop_front();
      compare({t, "/out_valid"}, 32'(out_valid), 32'd1);
      compare({t, "/f_out"}, f_out, held_f);
    end else begin
      compare({tag, "/idle_valid"}, 32'(out_valid), 32'd0);
      compare({tag, "/idle_hold"}, f_out, held_f);
    end
    in_valid = v;
    R_in     = r;
    subkey   = k;
    if (v) begin
      sb_q.push_back(exp);
      tag_q.push_back(tag);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    R_in     = vec_r[3];
    subkey   = vec_k[3];
    held_f   = '0;
    #2;
    compare("reset/f_out", f_out, 32'h0);
    compare("reset/out_valid", 32'(out_valid), 32'd0);
    // Reset must dominate a clock edge with in_valid high.
    @(posedge clk);
    #1;
    compare("reset_edge/f_out", f_out, 32'h0);
    compare("reset_edge/out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Isolated vectors: one valid cycle followed by an idle cycle.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vec_r[i], vec_k[i], vec_f[i], $sformatf("single%0d", i));
      step(1'b0, ~vec_r[i], vec_k[i] ^ 48'h5A5A5A5A5A5A, 32'h0, $sformatf("after%0d", i));
    end

    // Back-to-back streaming.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vec_r[i], vec_k[i], vec_f[i], $sformatf("stream%0d", i));
    end
    step(1'b0, 32'hDEADBEEF, 48'h123456789ABC, 32'h0, "stream_end");
    // Hold: inputs change while in_valid is low.
    step(1'b0, 32'h12345678, 48'hFEDCBA987654, 32'h0, "hold_a");
    step(1'b0, 32'h0F0F0F0F, 48'h0, 32'h0, "hold_b");

    // Mid-stream asynchronous reset.
    step(1'b1, vec_r[3], vec_k[3], vec_f[3], "pre_rst3");
    step(1'b1, vec_r[4], vec_k[4], vec_f[4], "pre_rst4");
    #3;
    rst_n = 1'b0;
    #1;
    compare("midreset/f_out", f_out, 32'h0);
    compare("midreset/out_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    tag_q.delete();
    held_f = '0;
    @(posedge clk);
    #1;
    compare("midreset_edge/f_out", f_out, 32'h0);
    compare("midreset_edge/out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step(1'b0, vec_r[5], vec_k[5], 32'h0, "post_rst_idle");
    step(1'b1, vec_r[5], vec_k[5], vec_f[5], "post_rst5");
    step(1'b0, 32'h0, 48'h0, 32'h0, "post_rst_tail");
    step(1'b0, 32'hFFFFFFFF, 48'h0, 32'h0, "final_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
